// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, N = WIDTH/DIGIT cycles per operation.
// Results and flags are loaded only at the DONE transition and held until the next DONE.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] work;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   sumd;
  logic [WIDTH-1:0] digext;
  logic [WIDTH-1:0] worknext;
  logic             cinmsb;
  logic             last;

  // Carry into the digit's top bit is recovered from the sum bit and the operand bits.
  always_comb begin
    sumd     = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + (DIGIT+1)'(carry);
    digext   = WIDTH'(sumd[DIGIT-1:0]);
    worknext = (work >> DIGIT) | (digext << (WIDTH - DIGIT));
    cinmsb   = sumd[DIGIT-1] ^ opa[DIGIT-1] ^ opb[DIGIT-1];
    last     = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      work  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          opa   <= opa >> DIGIT;
          opb   <= opb >> DIGIT;
          carry <= sumd[DIGIT];
          work  <= worknext;
          cnt   <= cnt + CW'(1);
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            s     <= worknext;
            cout  <= sumd[DIGIT];
            ovf   <= cinmsb ^ sumd[DIGIT];
            zero  <= (worknext == '0);
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1, so the inverted b and carry-in come from sub.
            state <= RUN;
            busy  <= 1'b1;
            opa   <= a;
            opb   <= b ^ {WIDTH{sub}};
            carry <= sub;
            cnt   <= '0;
            work  <= '0;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; legal values are >= 2.
REQ-002 SHALL have parameter DIGIT, default 1, giving the bits processed per clock; it must divide WIDTH, and N = WIDTH/DIGIT.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 SHALL have port nrst, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin an operation.
REQ-006 SHALL have port a, input, WIDTH bits: first operand (two's complement or unsigned).
REQ-007 SHALL have port b, input, WIDTH bits: second operand.
REQ-008 SHALL have port sub, input, 1 bit: 0 selects a+b, 1 selects a-b.
REQ-009 SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse marking the result as valid.
REQ-011 SHALL have port s, output, WIDTH bits: result.
REQ-012 SHALL have port cout, output, 1 bit: carry out of the MSB; for subtraction, 1 means no borrow.
REQ-013 SHALL have port ovf, output, 1 bit: signed overflow.
REQ-014 SHALL have port zero, output, 1 bit: the result equals 0.

Function
REQ-015 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-016 SHALL accept start only in IDLE or DONE, capturing a, b XOR {WIDTH{sub}}, and carry-in = sub; on acceptance it clears the digit counter and enters RUN.
REQ-017 SHALL, in RUN, add the low DIGIT bits of the captured operands plus the stored carry on each cycle, shift the sum digit into the working result from the MSB end, shift both operands right by DIGIT, and register the new carry.
REQ-018 SHALL, after N RUN cycles, enter DONE and load s, cout, ovf and zero from the working result in that same edge.
REQ-019 SHALL compute ovf as the carry into the MSB XOR the carry out of the MSB, both taken from the final digit.
REQ-020 SHALL assert done for exactly one cycle in DONE, exactly N cycles after the edge that sampled start.
REQ-021 SHALL leave DONE for IDLE on the next edge if start=0, or for RUN with new operands if start=1 (back-to-back, no bubble).
REQ-022 SHALL drive busy=1 only in RUN.
REQ-023 SHALL ignore start while busy=1, leaving operands, counter and outputs undisturbed.
REQ-024 SHALL hold s, cout, ovf and zero stable from one DONE until the next DONE, and never expose partial sums on them.
REQ-025 SHALL keep all arithmetic modulo 2^WIDTH; cout/ovf are the only indication of wrap.

Reset
REQ-026 SHALL, while nrst=0 and regardless of clk, force state IDLE, counter 0, carry 0, busy=0, done=0, s=0, cout=0, ovf=0, zero=0.
REQ-027 SHALL abandon any operation in progress on reset mid-RUN, with no done pulse on release.
REQ-028 SHALL honour start on the first rising edge after nrst deasserts.

Verification
REQ-029 SHALL pass: WIDTH=8, DIGIT=1, a=8'h7F, b=8'h01, sub=0 -> done 8 cycles after start, s=8'h80, cout=0, ovf=1, zero=0.
REQ-030 SHALL pass: WIDTH=8, DIGIT=1, a=8'h05, b=8'h05, sub=1 -> s=8'h00, cout=1, ovf=0, zero=1; and a=8'h00, b=8'h01, sub=1 -> s=8'hFF, cout=0, ovf=0.
REQ-031 SHALL pass: WIDTH=8, DIGIT=4, a=8'hFF, b=8'h01, sub=0 -> done 2 cycles after start, s=8'h00, cout=1, ovf=0, zero=1.
REQ-032 SHALL pass: start pulsed again at cycle 3 of a RUN with different operands -> ignored, first result unchanged, done timing unchanged.
REQ-033 SHALL pass: start held high through DONE with new operands a=8'h80, b=8'h01, sub=1 -> second op begins with no idle cycle, s=8'h7F, ovf=1, cout=1.
REQ-034 SHALL pass: nrst pulsed low asynchronously mid-RUN -> all outputs 0 immediately, no done pulse, next start completes correctly.
